// File: rtl/dcache_port_arbiter.sv
// Dcache request-port arbiter: loads (round-robin) and committed stores (prefix order) share
// NUM_PORTS registered request slots. Optional macro DCACHE_ARB_WORD_CONFLICT_EN blocks same-word loads.
package dcache_arb_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [2:0]  mem_func_t;

  typedef struct packed {
    logic      valid;
    addr_t     addr;
    mem_func_t sign_size;
    data_t     data;
  } sq_dcache_packet_t;

  typedef struct packed {
    logic      store;
    addr_t     addr;
    mem_func_t func;
    data_t     data;
    logic [2:0] src;
  } port_req_t;
endpackage

// One dcache port slot: loads on grant, drops valid once the dcache takes it.
module dcache_arb_port_reg
  import dcache_arb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  logic      ready,
  input  port_req_t d,
  output logic      valid,
  output port_req_t q
);
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int NUM_ST       = 2,
  parameter int NUM_LD       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  sq_dcache_packet_t [NUM_ST-1:0]   sq_req,
  output logic      [NUM_ST-1:0]           sq_accept,
  input  logic      [NUM_LD-1:0]           ld_valid,
  input  addr_t     [NUM_LD-1:0]           ld_addr,
  input  mem_func_t [NUM_LD-1:0]           ld_func,
  output logic      [NUM_LD-1:0]           ld_grant,
  output logic      [NUM_PORTS-1:0]        port_valid,
  output logic      [NUM_PORTS-1:0]        port_store,
  output addr_t     [NUM_PORTS-1:0]        port_addr,
  output mem_func_t [NUM_PORTS-1:0]        port_func,
  output data_t     [NUM_PORTS-1:0]        port_data,
  output logic      [NUM_PORTS-1:0][2:0]   port_src,
  input  logic      [NUM_PORTS-1:0]        port_ready
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int RW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [RW-1:0]             rr_ptr, rr_nxt;
  logic [CW-1:0]             starve_cnt, starve_nxt;
  logic [NUM_PORTS-1:0]      avail, load_en;
  logic [NUM_LD-1:0]         ld_block;
  port_req_t [NUM_PORTS-1:0] port_d, port_q;
  logic                      store_first, st_stop, ld_any;
  logic [PW-1:0]             pidx;
  int                        ld_last, li;

  function automatic logic [PW-1:0] first_set(input logic [NUM_PORTS-1:0] v);
    first_set = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--)
      if (v[p]) first_set = PW'(p);
  endfunction

`ifdef DCACHE_ARB_WORD_CONFLICT_EN
  logic st_live;
  // Stores that may go out this cycle are not known before loads are placed, so the
  // whole valid store prefix counts as a conflict; a blocked load simply retries.
  always_comb begin
    ld_block = '0;
    st_live  = 1'b1;
    for (int l = 0; l < NUM_LD; l++) begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (port_valid[p] && port_q[p].store && !port_ready[p] &&
            port_q[p].addr[31:2] == ld_addr[l][31:2])
          ld_block[l] = 1'b1;
      st_live = 1'b1;
      for (int s = 0; s < NUM_ST; s++) begin
        st_live = st_live & sq_req[s].valid;
        if (st_live && sq_req[s].addr[31:2] == ld_addr[l][31:2])
          ld_block[l] = 1'b1;
      end
    end
  end
`else
  assign ld_block = '0;
`endif

  always_comb begin
    avail       = reset ? '0 : (~port_valid | port_ready);
    store_first = (starve_cnt == CW'(STARVE_LIMIT));
    sq_accept   = '0;
    ld_grant    = '0;
    load_en     = '0;
    port_d      = '0;
    st_stop     = 1'b0;
    ld_any      = 1'b0;
    ld_last     = 0;
    li          = 0;
    pidx        = '0;
    // Phase order flips when stores are starving.
    for (int ph = 0; ph < 2; ph++) begin
      if ((ph == 0) == store_first) begin
        for (int s = 0; s < NUM_ST; s++) begin
          if (!st_stop) begin
            if (sq_req[s].valid && avail != '0) begin
              pidx               = first_set(avail);
              sq_accept[s]       = 1'b1;
              load_en[pidx]      = 1'b1;
              avail[pidx]        = 1'b0;
              port_d[pidx].store = 1'b1;
              port_d[pidx].addr  = sq_req[s].addr;
              port_d[pidx].func  = sq_req[s].sign_size;
              port_d[pidx].data  = sq_req[s].data;
              port_d[pidx].src   = 3'(s);
            end else begin
              st_stop = 1'b1;
            end
          end
        end
      end else begin
        for (int k = 0; k < NUM_LD; k++) begin
          li = int'(rr_ptr) + k;
          if (li >= NUM_LD) li = li - NUM_LD;
          if (ld_valid[li] && !ld_block[li] && avail != '0) begin
            pidx               = first_set(avail);
            ld_grant[li]       = 1'b1;
            load_en[pidx]      = 1'b1;
            avail[pidx]        = 1'b0;
            port_d[pidx].store = 1'b0;
            port_d[pidx].addr  = ld_addr[li];
            port_d[pidx].func  = ld_func[li];
            port_d[pidx].data  = '0;
            port_d[pidx].src   = 3'(li);
            ld_any             = 1'b1;
            ld_last            = li;
          end
        end
      end
    end
    rr_nxt = ld_any ? RW'((ld_last + 1) % NUM_LD) : rr_ptr;
    if (sq_req[0].valid && !sq_accept[0])
      starve_nxt = store_first ? starve_cnt : starve_cnt + CW'(1);
    else
      starve_nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      rr_ptr     <= rr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dcache_arb_port_reg u_reg (
      .clock (clock),
      .reset (reset),
      .load  (load_en[p]),
      .ready (port_ready[p]),
      .d     (port_d[p]),
      .valid (port_valid[p]),
      .q     (port_q[p])
    );
    assign port_store[p] = port_q[p].store;
    assign port_addr[p]  = port_q[p].addr;
    assign port_func[p]  = port_q[p].func;
    assign port_data[p]  = port_q[p].data;
    assign port_src[p]   = port_q[p].src;
  end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: vector table, directed corner sequences, random traffic vs a model.
module tb_dcache_port_arbiter;
  import dcache_arb_pkg::*;
  localparam int NP = 2, NS = 2, NL = 3, LIM = 4;

  logic clock = 1'b0, reset = 1'b1;
  sq_dcache_packet_t [NS-1:0] sq_req;
  logic [NS-1:0] sq_accept;
  logic [NL-1:0] ld_valid, ld_grant;
  addr_t [NL-1:0] ld_addr;
  mem_func_t [NL-1:0] ld_func;
  logic [NP-1:0] port_valid, port_store, port_ready;
  addr_t [NP-1:0] port_addr;
  mem_func_t [NP-1:0] port_func;
  data_t [NP-1:0] port_data;
  logic [NP-1:0][2:0] port_src;

  dcache_port_arbiter #(.NUM_PORTS(NP), .NUM_ST(NS), .NUM_LD(NL), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .sq_req(sq_req), .sq_accept(sq_accept),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_func(ld_func), .ld_grant(ld_grant),
    .port_valid(port_valid), .port_store(port_store), .port_addr(port_addr),
    .port_func(port_func), .port_data(port_data), .port_src(port_src), .port_ready(port_ready)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: slot contents plus the two pieces of arbiter state.
  bit        m_v[NP];
  port_req_t m_q[NP];
  int        m_rr = 0, m_starve = 0;
  logic [NS-1:0] exp_sq, last_sq;
  logic [NL-1:0] exp_ld, last_ld;
  int        freeq[$], g_port[$];
  port_req_t g_req[$];
  int        g_last, prefix;
  bit        g_any;

  function automatic bit blocked(input int l);
    blocked = 1'b0;
`ifdef DCACHE_ARB_WORD_CONFLICT_EN
    for (int p = 0; p < NP; p++)
      if (m_v[p] && m_q[p].store && !port_ready[p] && m_q[p].addr[31:2] == ld_addr[l][31:2]) blocked = 1'b1;
    for (int s = 0; s < prefix; s++)
      if (sq_req[s].addr[31:2] == ld_addr[l][31:2]) blocked = 1'b1;
`else
    if (l < 0) blocked = 1'b1;
`endif
  endfunction

  task automatic grant_stores();
    int n;
    port_req_t r;
    n = (prefix < freeq.size()) ? prefix : freeq.size();
    for (int i = 0; i < n; i++) begin
      r.store = 1'b1; r.addr = sq_req[i].addr; r.func = sq_req[i].sign_size;
      r.data = sq_req[i].data; r.src = 3'(i);
      exp_sq[i] = 1'b1;
      g_port.push_back(freeq.pop_front());
      g_req.push_back(r);
    end
  endtask

  task automatic grant_loads();
    int l;
    port_req_t r;
    for (int k = 0; k < NL; k++) begin
      l = (m_rr + k) % NL;
      if (freeq.size() != 0 && ld_valid[l] && !blocked(l)) begin
        r.store = 1'b0; r.addr = ld_addr[l]; r.func = ld_func[l]; r.data = '0; r.src = 3'(l);
        exp_ld[l] = 1'b1;
        g_port.push_back(freeq.pop_front());
        g_req.push_back(r);
        g_any = 1'b1;
        g_last = l;
      end
    end
  endtask

  task automatic model_comb();
    exp_sq = '0; exp_ld = '0; g_any = 1'b0; g_last = 0;
    freeq = {}; g_port = {}; g_req = {};
    if (reset) return;
    for (int p = 0; p < NP; p++) if (!m_v[p] || port_ready[p]) freeq.push_back(p);
    prefix = 0;
    while (prefix < NS && sq_req[prefix].valid) prefix++;
    if (m_starve == LIM) begin grant_stores(); grant_loads(); end
    else begin grant_loads(); grant_stores(); end
  endtask

  task automatic model_seq();
    if (reset) begin
      for (int p = 0; p < NP; p++) begin m_v[p] = 1'b0; m_q[p] = '0; end
      m_rr = 0; m_starve = 0;
      return;
    end
    for (int p = 0; p < NP; p++) if (port_ready[p]) m_v[p] = 1'b0;
    foreach (g_port[i]) begin m_v[g_port[i]] = 1'b1; m_q[g_port[i]] = g_req[i]; end
    if (g_any) m_rr = (g_last + 1) % NL;
    if (sq_req[0].valid && !exp_sq[0]) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    else m_starve = 0;
  endtask

  // Inputs are set just after a rising edge; grants checked mid-cycle, slots after the edge.
  task automatic step();
    port_req_t a;
    logic [NP-1:0] mv;
    #2;
    model_comb();
    last_sq = sq_accept; last_ld = ld_grant;
    chk("sq_accept", 128'(sq_accept), 128'(exp_sq));
    chk("ld_grant", 128'(ld_grant), 128'(exp_ld));
    @(posedge clock);
    model_seq();
    #1;
    for (int p = 0; p < NP; p++) mv[p] = m_v[p];
    chk("port_valid", 128'(port_valid), 128'(mv));
    for (int p = 0; p < NP; p++) if (m_v[p]) begin
      a.store = port_store[p]; a.addr = port_addr[p]; a.func = port_func[p];
      a.data = port_data[p]; a.src = port_src[p];
      chk($sformatf("port%0d_reg", p), 128'(a), 128'(m_q[p]));
    end
  endtask

  task automatic set_in(input logic [NL-1:0] ld, input logic [NS-1:0] sq, input logic [NP-1:0] rdy);
    ld_valid = ld;
    for (int i = 0; i < NS; i++) sq_req[i].valid = sq[i];
    port_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in('0, '0, '1);
    step(); step();
    reset = 1'b0;
  endtask

  task automatic default_addrs();
    for (int i = 0; i < NS; i++) begin
      sq_req[i].addr = 32'h2000 + 32'(16 * i);
      sq_req[i].data = 32'hD000_0000 + 32'(i);
      sq_req[i].sign_size = 3'b010;
    end
    for (int i = 0; i < NL; i++) begin
      ld_addr[i] = 32'h100 + 32'(16 * i);
      ld_func[i] = 3'(i);
    end
  endtask

  typedef struct {
    logic [NL-1:0] ld;
    logic [NS-1:0] sq;
    logic [NP-1:0] rdy;
    logic [NL-1:0] e_ld;
    logic [NS-1:0] e_sq;
  } vec_t;
  vec_t tbl[7];

  initial begin
    sq_req = '0; ld_valid = '0; ld_addr = '0; ld_func = '0; port_ready = '1;
    default_addrs();
    for (int p = 0; p < NP; p++) begin m_v[p] = 1'b0; m_q[p] = '0; end

    tbl[0] = '{3'b011, 2'b00, 2'b11, 3'b011, 2'b00};
    tbl[1] = '{3'b000, 2'b01, 2'b00, 3'b000, 2'b00};
    tbl[2] = '{3'b000, 2'b11, 2'b01, 3'b000, 2'b01};
    tbl[3] = '{3'b111, 2'b00, 2'b11, 3'b101, 2'b00};
    tbl[4] = '{3'b111, 2'b00, 2'b10, 3'b010, 2'b00};
    tbl[5] = '{3'b000, 2'b10, 2'b11, 3'b000, 2'b00};
    tbl[6] = '{3'b100, 2'b11, 2'b11, 3'b100, 2'b01};

    do_reset();
    chk("reset_port_valid", 128'(port_valid), 128'(0));
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].ld, tbl[i].sq, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_ld", i), 128'(last_ld), 128'(tbl[i].e_ld));
      chk($sformatf("tbl%0d_sq", i), 128'(last_sq), 128'(tbl[i].e_sq));
      if (i == 0) chk("tbl0_port_store", 128'(port_store), 128'(0));
    end

    // Stores granted once, then held while the dcache stalls.
    do_reset();
    set_in(3'b000, 2'b11, 2'b11); step();
    chk("hold_first_sq", 128'(last_sq), 128'(2'b11));
    for (int c = 0; c < 3; c++) begin
      set_in(3'b000, 2'b11, 2'b00); step();
      chk("hold_no_grant", 128'(last_sq), 128'(0));
      chk("hold_addr0", 128'(port_addr[0]), 128'(32'h2000));
      chk("hold_data1", 128'(port_data[1]), 128'(32'hD000_0001));
    end
    set_in(3'b000, 2'b11, 2'b11); step();
    chk("hold_release_sq", 128'(last_sq), 128'(2'b11));

    // Starvation: store blocked four cycles, wins on the fifth.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      set_in(3'b111, 2'b01, 2'b11); step();
      chk($sformatf("starve_c%0d", c), 128'(last_sq[0]), 128'(c == 5));
    end

    // Round-robin rotation among three loads.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      logic [NL-1:0] e;
      e = (c % 3 == 0) ? 3'b011 : (c % 3 == 1) ? 3'b101 : 3'b110;
      set_in(3'b111, 2'b00, 2'b11); step();
      chk($sformatf("rr_c%0d", c), 128'(last_ld), 128'(e));
    end

`ifdef DCACHE_ARB_WORD_CONFLICT_EN
    do_reset();
    sq_req[0].addr = 32'h1004; ld_addr[0] = 32'h1006;
    set_in(3'b000, 2'b01, 2'b00); step();
    chk("wc_store", 128'(last_sq), 128'(2'b01));
    for (int c = 0; c < 2; c++) begin
      set_in(3'b001, 2'b00, 2'b00); step();
      chk("wc_blocked", 128'(last_ld), 128'(0));
    end
    set_in(3'b001, 2'b00, 2'b01); step();
    chk("wc_granted", 128'(last_ld), 128'(3'b001));
    default_addrs();
`endif

    // Random traffic against the model, with occasional mid-run reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      ld_valid = NL'($urandom);
      for (int i = 0; i < NS; i++) begin
        sq_req[i].valid = ($urandom_range(0, 2) != 0);
`ifdef DCACHE_ARB_WORD_CONFLICT_EN
        sq_req[i].addr = 32'h1000 + 32'($urandom_range(0, 15));
`else
        sq_req[i].addr = $urandom;
`endif
        sq_req[i].data = $urandom;
        sq_req[i].sign_size = 3'($urandom);
      end
      for (int i = 0; i < NL; i++) begin
`ifdef DCACHE_ARB_WORD_CONFLICT_EN
        ld_addr[i] = 32'h1000 + 32'($urandom_range(0, 15));
`else
        ld_addr[i] = $urandom;
`endif
        ld_func[i] = 3'($urandom);
      end
      for (int p = 0; p < NP; p++) port_ready[p] = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
